// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the pong game-state and scoring logic.
//   game_state_t : game sequencing states (IDLE, SERVE_WAIT, PLAY, OVER)
//   WIN_*        : codes driven on the WINNER output
//   BCD_DIGIT_W  : width of one packed-BCD digit; SCORE_W holds two digits
//   bcd_inc      : two-digit BCD increment (ones roll into tens)
//   bcd_value    : binary value of a two-digit BCD score
// ---------------------------------------------------------------------------
package pong_pkg;

   localparam int BCD_DIGIT_W = 4;
   localparam int SCORE_W     = 2 * BCD_DIGIT_W;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SERVE_WAIT = 2'd1,
      PLAY       = 2'd2,
      OVER       = 2'd3
   } game_state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_ONE  = 2'b01;
   localparam logic [1:0] WIN_TWO  = 2'b10;

   // Scores never pass the winning score (at most 99), so the tens digit
   // is never incremented past 9 and no wrap handling is required.
   function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
      logic [BCD_DIGIT_W-1:0] ones_s;
      logic [BCD_DIGIT_W-1:0] tens_s;
      ones_s = v[BCD_DIGIT_W-1:0];
      tens_s = v[SCORE_W-1:BCD_DIGIT_W];
      if (ones_s == 4'd9) begin
         ones_s = 4'd0;
         tens_s = tens_s + 4'd1;
      end else begin
         ones_s = ones_s + 4'd1;
      end
      return {tens_s, ones_s};
   endfunction

   function automatic int bcd_value(input logic [SCORE_W-1:0] v);
      return int'(v[SCORE_W-1:BCD_DIGIT_W]) * 32'sd10 + int'(v[BCD_DIGIT_W-1:0]);
   endfunction

endpackage

// File: rtl/bcd_counter2.sv
// ---------------------------------------------------------------------------
// bcd_counter2
// Two-digit packed-BCD score register with synchronous clear and increment.
// Clear wins over increment.
//   clk     : system clock
//   reset_n : synchronous active-low reset, clears the count
//   clr     : clear count to 8'h00 on the next edge
//   inc     : increment count by one (BCD) on the next edge
//   value   : registered score, [7:4] tens, [3:0] ones
// ---------------------------------------------------------------------------
module bcd_counter2
   import pong_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clr,
   input  logic               inc,
   output logic [SCORE_W-1:0] value
);

   logic [SCORE_W-1:0] count_r;

   // Score register: reset/clear to zero, otherwise optional BCD increment.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_r <= 8'h00;
      end else if (clr) begin
         count_r <= 8'h00;
      end else if (inc) begin
         count_r <= bcd_inc(count_r);
      end else begin
         count_r <= count_r;
      end
   end

   assign value = count_r;

endmodule

// File: rtl/score_keeper.sv
// ---------------------------------------------------------------------------
// score_keeper
// Game sequencer and score keeper for pong. Detects rising edges on the goal
// and new-game inputs, runs the serve delay, releases the ball, counts
// points in packed BCD and declares the winner.
//   WIN_SCORE   : points needed to win (1..99)
//   SERVE_DELAY : cycles spent in SERVE_WAIT before each serve (>= 1)
//   clk         : system clock
//   reset_n     : synchronous active-low reset
//   GOAL_ONE    : level, point to player one (only the rising edge counts)
//   GOAL_TWO    : level, point to player two (only the rising edge counts)
//   NEW_GAME    : level, rising edge starts/restarts a game
//   PLAYER_ONE  : player one score, packed BCD
//   PLAYER_TWO  : player two score, packed BCD
//   SERVE       : one-cycle pulse in the first PLAY cycle
//   PLAYING     : high while in PLAY
//   WINNER      : WIN_NONE / WIN_ONE / WIN_TWO
// ---------------------------------------------------------------------------
module score_keeper
   import pong_pkg::*;
#(
   parameter int WIN_SCORE   = 11,
   parameter int SERVE_DELAY = 50_000_000
)(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               GOAL_ONE,
   input  logic               GOAL_TWO,
   input  logic               NEW_GAME,
   output logic [SCORE_W-1:0] PLAYER_ONE,
   output logic [SCORE_W-1:0] PLAYER_TWO,
   output logic               SERVE,
   output logic               PLAYING,
   output logic [1:0]         WINNER
);

   localparam int                 TIMER_W    = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
   localparam logic [TIMER_W-1:0] TIMER_TERM = TIMER_W'(SERVE_DELAY - 1);

   logic goal_one_prev_r;
   logic goal_two_prev_r;
   logic new_game_prev_r;
   logic goal_one_rise_s;
   logic goal_two_rise_s;
   logic new_game_rise_s;

   game_state_t        state_r;
   game_state_t        state_next_s;
   logic [TIMER_W-1:0] timer_r;
   logic [TIMER_W-1:0] timer_next_s;
   logic               serve_r;
   logic               serve_next_s;
   logic               playing_r;
   logic               playing_next_s;
   logic [1:0]         winner_r;
   logic [1:0]         winner_next_s;

   logic               clr_s;
   logic               inc_one_s;
   logic               inc_two_s;
   logic [SCORE_W-1:0] score_one_s;
   logic [SCORE_W-1:0] score_two_s;
   logic               one_wins_s;
   logic               two_wins_s;

   assign goal_one_rise_s = GOAL_ONE & ~goal_one_prev_r;
   assign goal_two_rise_s = GOAL_TWO & ~goal_two_prev_r;
   assign new_game_rise_s = NEW_GAME & ~new_game_prev_r;

   // Compare the post-increment score so the winner is known on the same
   // edge that the winning point is registered.
   assign one_wins_s = (bcd_value(bcd_inc(score_one_s)) == WIN_SCORE);
   assign two_wins_s = (bcd_value(bcd_inc(score_two_s)) == WIN_SCORE);

   // Previous-value registers for edge detection; sampled in every state so a
   // level already high when PLAY is entered cannot score.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         goal_one_prev_r <= 1'b0;
         goal_two_prev_r <= 1'b0;
         new_game_prev_r <= 1'b0;
      end else begin
         goal_one_prev_r <= GOAL_ONE;
         goal_two_prev_r <= GOAL_TWO;
         new_game_prev_r <= NEW_GAME;
      end
   end

   // State, serve timer and registered status outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r   <= IDLE;
         timer_r   <= '0;
         serve_r   <= 1'b0;
         playing_r <= 1'b0;
         winner_r  <= WIN_NONE;
      end else begin
         state_r   <= state_next_s;
         timer_r   <= timer_next_s;
         serve_r   <= serve_next_s;
         playing_r <= playing_next_s;
         winner_r  <= winner_next_s;
      end
   end

   // Next-state, timer and score-control decode.
   always_comb begin
      state_next_s  = state_r;
      timer_next_s  = timer_r;
      serve_next_s  = 1'b0;
      winner_next_s = winner_r;
      clr_s         = 1'b0;
      inc_one_s     = 1'b0;
      inc_two_s     = 1'b0;

      // A new-game edge restarts from any state and beats a simultaneous goal.
      if (new_game_rise_s) begin
         state_next_s  = SERVE_WAIT;
         timer_next_s  = '0;
         winner_next_s = WIN_NONE;
         clr_s         = 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               state_next_s = IDLE;
            end
            SERVE_WAIT: begin
               if (timer_r == TIMER_TERM) begin
                  state_next_s = PLAY;
                  timer_next_s = '0;
                  serve_next_s = 1'b1;
               end else begin
                  timer_next_s = timer_r + TIMER_W'(1);
               end
            end
            PLAY: begin
               if (goal_one_rise_s && goal_two_rise_s) begin
                  // Void point: nobody scores, serve again.
                  state_next_s = SERVE_WAIT;
                  timer_next_s = '0;
               end else if (goal_one_rise_s) begin
                  inc_one_s    = 1'b1;
                  timer_next_s = '0;
                  if (one_wins_s) begin
                     state_next_s  = OVER;
                     winner_next_s = WIN_ONE;
                  end else begin
                     state_next_s = SERVE_WAIT;
                  end
               end else if (goal_two_rise_s) begin
                  inc_two_s    = 1'b1;
                  timer_next_s = '0;
                  if (two_wins_s) begin
                     state_next_s  = OVER;
                     winner_next_s = WIN_TWO;
                  end else begin
                     state_next_s = SERVE_WAIT;
                  end
               end else begin
                  state_next_s = PLAY;
               end
            end
            OVER: begin
               state_next_s = OVER;
            end
            default: begin
               state_next_s  = IDLE;
               timer_next_s  = '0;
               winner_next_s = WIN_NONE;
               clr_s         = 1'b1;
            end
         endcase
      end

      playing_next_s = (state_next_s == PLAY);
   end

   bcd_counter2 u_score_one (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr_s),
      .inc     (inc_one_s),
      .value   (score_one_s)
   );

   bcd_counter2 u_score_two (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr_s),
      .inc     (inc_two_s),
      .value   (score_two_s)
   );

   assign PLAYER_ONE = score_one_s;
   assign PLAYER_TWO = score_two_s;
   assign SERVE      = serve_r;
   assign PLAYING    = playing_r;
   assign WINNER     = winner_r;

endmodule

// File: tb/tb_score_keeper.sv
// ---------------------------------------------------------------------------
// tb_score_keeper
// Directed scenarios followed by random stimulus, every cycle compared with
// a behavioural model that keeps scores as plain integers and the serve
// delay as a countdown.
// ---------------------------------------------------------------------------
module tb_score_keeper;

   localparam int WIN   = 11;
   localparam int DELAY = 4;

   localparam int PH_IDLE = 0;
   localparam int PH_WAIT = 1;
   localparam int PH_PLAY = 2;
   localparam int PH_OVER = 3;

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b0;
   logic       GOAL_ONE = 1'b0;
   logic       GOAL_TWO = 1'b0;
   logic       NEW_GAME = 1'b0;
   logic [7:0] PLAYER_ONE;
   logic [7:0] PLAYER_TWO;
   logic       SERVE;
   logic       PLAYING;
   logic [1:0] WINNER;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model state
   int m_s1, m_s2, m_win, m_phase, m_left;
   bit m_serve, m_playing;
   bit m_p1, m_p2, m_pn;
   int serve_seen;

   always #5 clk = ~clk;

   score_keeper #(.WIN_SCORE(WIN), .SERVE_DELAY(DELAY)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .GOAL_ONE   (GOAL_ONE),
      .GOAL_TWO   (GOAL_TWO),
      .NEW_GAME   (NEW_GAME),
      .PLAYER_ONE (PLAYER_ONE),
      .PLAYER_TWO (PLAYER_TWO),
      .SERVE      (SERVE),
      .PLAYING    (PLAYING),
      .WINNER     (WINNER)
   );

   function automatic logic [7:0] to_bcd(input int s);
      logic [7:0] r;
      r[7:4] = 4'(s / 10);
      r[3:0] = 4'(s % 10);
      return r;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Advance the model by one clock edge given the inputs sampled there.
   task automatic model_edge(input bit rn, input bit g1, input bit g2, input bit ng);
      bit e1, e2, en;
      e1 = g1 && !m_p1;
      e2 = g2 && !m_p2;
      en = ng && !m_pn;
      m_serve = 1'b0;
      if (!rn) begin
         m_s1 = 0; m_s2 = 0; m_win = 0; m_phase = PH_IDLE; m_left = 0;
         m_p1 = 1'b0; m_p2 = 1'b0; m_pn = 1'b0;
      end else begin
         m_p1 = g1; m_p2 = g2; m_pn = ng;
         if (en) begin
            m_s1 = 0; m_s2 = 0; m_win = 0;
            m_phase = PH_WAIT; m_left = DELAY;
         end else if (m_phase == PH_WAIT) begin
            m_left--;
            if (m_left == 0) begin
               m_phase = PH_PLAY;
               m_serve = 1'b1;
            end
         end else if (m_phase == PH_PLAY) begin
            if (e1 && e2) begin
               m_phase = PH_WAIT; m_left = DELAY;
            end else if (e1) begin
               m_s1++;
               if (m_s1 == WIN) begin m_phase = PH_OVER; m_win = 1; end
               else begin m_phase = PH_WAIT; m_left = DELAY; end
            end else if (e2) begin
               m_s2++;
               if (m_s2 == WIN) begin m_phase = PH_OVER; m_win = 2; end
               else begin m_phase = PH_WAIT; m_left = DELAY; end
            end
         end
      end
      m_playing = (m_phase == PH_PLAY);
   endtask

   // Drive inputs, clock once, then compare all outputs with the model.
   task automatic step(input bit rn, input bit g1, input bit g2, input bit ng);
      reset_n  = rn;
      GOAL_ONE = g1;
      GOAL_TWO = g2;
      NEW_GAME = ng;
      @(posedge clk);
      model_edge(rn, g1, g2, ng);
      @(negedge clk);
      check_eq("player_one", 32'(PLAYER_ONE), 32'(to_bcd(m_s1)));
      check_eq("player_two", 32'(PLAYER_TWO), 32'(to_bcd(m_s2)));
      check_eq("serve",      32'(SERVE),      32'(m_serve));
      check_eq("playing",    32'(PLAYING),    32'(m_playing));
      check_eq("winner",     32'(WINNER),     32'(m_win));
      if (SERVE) serve_seen++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      m_s1 = 0; m_s2 = 0; m_win = 0; m_phase = PH_IDLE; m_left = 0;
      m_serve = 1'b0; m_playing = 1'b0;
      m_p1 = 1'b0; m_p2 = 1'b0; m_pn = 1'b0;
      serve_seen = 0;

      // Reset, then idle with goal pulses that must be ignored
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 100; i++)
         step(1'b1, (i % 10) == 3, (i % 10) == 7, 1'b0);
      check_eq("idle_p1", 32'(PLAYER_ONE), 32'h00);
      check_eq("idle_p2", 32'(PLAYER_TWO), 32'h00);
      check_eq("idle_serves", 32'(serve_seen), 32'd0);

      // New game: four wait cycles, then a single serve and PLAYING held high
      step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < DELAY - 1; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b1);
         check_eq("wait_playing", 32'(PLAYING), 32'd0);
      end
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("first_serve", 32'(SERVE), 32'd1);
      check_eq("first_playing", 32'(PLAYING), 32'd1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("serve_once", 32'(serve_seen), 32'd1);
      check_eq("still_playing", 32'(PLAYING), 32'd1);
      idle(2);

      // Ten goals for player one: 01..09 then 10
      for (int k = 1; k <= 10; k++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0);
         check_eq("p1_step", 32'(PLAYER_ONE), 32'(to_bcd(k)));
         check_eq("p2_zero", 32'(PLAYER_TWO), 32'h00);
         idle(DELAY);
      end
      check_eq("p1_ten", 32'(PLAYER_ONE), 32'h10);

      // Void point: both goals together
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check_eq("void_p1", 32'(PLAYER_ONE), 32'h10);
      check_eq("void_p2", 32'(PLAYER_TWO), 32'h00);
      for (int i = 0; i < DELAY - 1; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         check_eq("void_wait", 32'(PLAYING), 32'd0);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("void_serve", 32'(SERVE), 32'd1);

      // Player two scores, then holds GOAL_TWO high through the serve
      step(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < DELAY + 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
      check_eq("held_no_score", 32'(PLAYER_TWO), 32'h01);
      check_eq("held_playing", 32'(PLAYING), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check_eq("reraise_score", 32'(PLAYER_TWO), 32'h02);
      idle(DELAY);

      // Player two runs to 11 and wins
      for (int k = 3; k <= WIN; k++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0);
         check_eq("p2_step", 32'(PLAYER_TWO), 32'(to_bcd(k)));
         if (k < WIN) idle(DELAY);
      end
      check_eq("win_score", 32'(PLAYER_TWO), 32'h11);
      check_eq("win_code", 32'(WINNER), 32'd2);
      check_eq("win_playing", 32'(PLAYING), 32'd0);
      serve_seen = 0;
      idle(10);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      idle(3);
      check_eq("over_no_serve", 32'(serve_seen), 32'd0);
      check_eq("over_p1", 32'(PLAYER_ONE), 32'h10);
      check_eq("over_p2", 32'(PLAYER_TWO), 32'h11);

      // Restart from OVER
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("restart_p2", 32'(PLAYER_TWO), 32'h00);
      check_eq("restart_win", 32'(WINNER), 32'd0);
      for (int i = 0; i < DELAY - 1; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("restart_serve", 32'(SERVE), 32'd1);

      // Reset in the middle of SERVE_WAIT
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      serve_seen = 0;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      idle(10);
      check_eq("rst_no_serve", 32'(serve_seen), 32'd0);
      check_eq("rst_playing", 32'(PLAYING), 32'd0);

      // Random stimulus against the model
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 499) != 0,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 79) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
